// File: rtl/sync_fifo_reader.sv
// Drains a handshake-free sync FIFO into a valid/ready stream framed as PKT_LEN-beat packets.
// Define FIFO_RD_STATS_EN to add the saturating stall counter port stat_stall_cnt.
module sync_fifo_reader #(
    parameter int DATA_WIDTH = 64,
    parameter int PKT_LEN    = 8
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [31:0]           stat_stall_cnt
`endif
);

    localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(PKT_LEN - 1);

    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [1:0]            occ_r;
    logic                  inflight_r;
    logic [BEAT_W-1:0]     beat_r;
    logic                  valid_r;
    logic                  last_r;

    logic [DATA_WIDTH-1:0] head_s;
    logic [DATA_WIDTH-1:0] tail_s;
    logic [1:0]            occ_s;
    logic [BEAT_W-1:0]     beat_s;
    logic                  valid_s;
    logic                  last_s;
    logic                  pop_s;
    logic [2:0]            commit_s;
    logic                  rd_en_s;

    assign pop_s = valid_r & out_ready;

    // Issue a read only if the word it returns is guaranteed a buffer slot.
    always_comb begin
        commit_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (rst && !fifo_empty && (commit_s < 3'd2)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Two-entry buffer update: capture of the in-flight word and/or pop of the head.
    always_comb begin
        head_s = head_r;
        tail_s = tail_r;
        occ_s  = occ_r;
        case ({inflight_r, pop_s})
            2'b10: begin
                if (occ_r == 2'd0) begin
                    head_s = fifo_dout;
                    occ_s  = 2'd1;
                end else begin
                    tail_s = fifo_dout;
                    occ_s  = 2'd2;
                end
            end
            2'b01: begin
                if (occ_r == 2'd2) begin
                    head_s = tail_r;
                    occ_s  = 2'd1;
                end else begin
                    occ_s  = 2'd0;
                end
            end
            2'b11: begin
                if (occ_r == 2'd2) begin
                    head_s = tail_r;
                    tail_s = fifo_dout;
                end else begin
                    head_s = fifo_dout;
                end
            end
            default: begin
                occ_s = occ_r;
            end
        endcase
    end

    // Beat counter advances only on an accepted beat; last is precomputed for the next cycle.
    always_comb begin
        if (pop_s) begin
            if (beat_r == BEAT_MAX) begin
                beat_s = {BEAT_W{1'b0}};
            end else begin
                beat_s = beat_r + BEAT_W'(1);
            end
        end else begin
            beat_s = beat_r;
        end
        valid_s = (occ_s != 2'd0);
        last_s  = valid_s && (beat_s == BEAT_MAX);
    end

    // Datapath and control state registers.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            head_r     <= {DATA_WIDTH{1'b0}};
            tail_r     <= {DATA_WIDTH{1'b0}};
            occ_r      <= 2'd0;
            inflight_r <= 1'b0;
            beat_r     <= {BEAT_W{1'b0}};
            valid_r    <= 1'b0;
            last_r     <= 1'b0;
        end else begin
            head_r     <= head_s;
            tail_r     <= tail_s;
            occ_r      <= occ_s;
            inflight_r <= rd_en_s;
            beat_r     <= beat_s;
            valid_r    <= valid_s;
            last_r     <= last_s;
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign out_valid  = valid_r;
    assign out_data   = head_r;
    assign out_last   = last_r;

`ifdef FIFO_RD_STATS_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of cycles the consumer held off a valid beat.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 32'd0;
        end else if (valid_r && !out_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stat_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader: a simple registered-output FIFO model feeds the DUT.
module tb_sync_fifo_reader;

    logic        clock = 1'b0;
    logic        rst;
    logic [63:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] stat_stall_cnt;
`endif

    logic [63:0] mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        load_stale = 1'b0;
    logic [63:0] stale_val = 64'd0;

    int          checks = 0;
    int          errors = 0;
    int          exp_beat = 0;
    logic [63:0] exp_next = 64'd0;

    always #5 clock = ~clock;

    sync_fifo_reader #(.DATA_WIDTH(64), .PKT_LEN(8)) dut (
        .clock          (clock),
        .rst            (rst),
        .fifo_dout      (fifo_dout),
        .fifo_empty     (fifo_empty),
        .fifo_rd_en     (fifo_rd_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last)
`ifdef FIFO_RD_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    assign fifo_empty = (wr_ptr == rd_ptr);

    // FIFO model: dout is registered one cycle after a read; otherwise it holds (stale).
    always @(posedge clock) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_ptr % 256];
            rd_ptr    <= rd_ptr + 1;
        end else if (load_stale) begin
            fifo_dout <= stale_val;
        end
    end

    task automatic push(input logic [63:0] v);
        mem[wr_ptr % 256] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        out_ready = 1'b0;
        #1;
        rst = 1'b0;
        push(64'h55);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %0b expected 0", out_last); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data: got %0h expected 0", out_data); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %0b expected 0", fifo_rd_en); end
`ifdef FIFO_RD_STATS_EN
        checks++; if (stat_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: got %0d expected 0", stat_stall_cnt); end
`endif
        tick;
        tick;
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en_hold: got %0b expected 0", fifo_rd_en); end
        wr_ptr = rd_ptr;
        rst = 1'b1;
        tick;
    endtask

    task automatic test_streaming;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) push(64'(i));
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (fifo_rd_en !== (c < 16)) begin errors++; $display("FAIL stream_rd_en c=%0d: got %0b expected %0b", c, fifo_rd_en, (c < 16)); end
            checks++; if (out_valid !== (c >= 2 && c < 18)) begin errors++; $display("FAIL stream_valid c=%0d: got %0b expected %0b", c, out_valid, (c >= 2 && c < 18)); end
            if (c >= 2 && c < 18) begin
                checks++; if (out_data !== 64'(c - 2)) begin errors++; $display("FAIL stream_data c=%0d: got %0h expected %0h", c, out_data, c - 2); end
                checks++; if (out_last !== (((c - 2) % 8) == 7)) begin errors++; $display("FAIL stream_last c=%0d: got %0b expected %0b", c, out_last, (((c - 2) % 8) == 7)); end
            end
            tick;
        end
    endtask

    task automatic test_empty_gap;
        exp_next = 64'd200;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(64'd200 + 64'(i));
        for (int c = 0; c < 20; c++) begin
            if (c == 10) begin
                for (int i = 3; i < 8; i++) push(64'd200 + 64'(i));
            end
            #1;
            if (c >= 6 && c < 10) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid c=%0d: got %0b expected 0", c, out_valid); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_data !== exp_next) begin errors++; $display("FAIL gap_data: got %0h expected %0h", out_data, exp_next); end
                checks++; if (out_last !== (exp_beat == 7)) begin errors++; $display("FAIL gap_last: got %0b expected %0b", out_last, (exp_beat == 7)); end
                exp_next = exp_next + 64'd1;
                exp_beat = (exp_beat + 1) % 8;
            end
            tick;
        end
        checks++; if (exp_next !== 64'd208) begin errors++; $display("FAIL gap_count: got %0h expected %0h", exp_next, 64'd208); end
    endtask

    task automatic test_backpressure;
        int reads;
        reads = 0;
        exp_next = 64'd100;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(64'd100 + 64'(i));
        for (int c = 0; c < 7; c++) begin
            #1;
            if (fifo_rd_en) reads++;
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid c=%0d: got %0b expected 1", c, out_valid); end
                checks++; if (out_data !== 64'd100) begin errors++; $display("FAIL bp_hold c=%0d: got %0h expected 64", c, out_data); end
                checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL bp_last c=%0d: got %0b expected 0", c, out_last); end
            end
            tick;
        end
        checks++; if (reads !== 2) begin errors++; $display("FAIL bp_reads: got %0d expected 2", reads); end
`ifdef FIFO_RD_STATS_EN
        checks++; if (stat_stall_cnt !== 32'd5) begin errors++; $display("FAIL bp_stall: got %0d expected 5", stat_stall_cnt); end
`endif
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid && out_ready) begin
                checks++; if (out_data !== exp_next) begin errors++; $display("FAIL bp_data: got %0h expected %0h", out_data, exp_next); end
                checks++; if (out_last !== (exp_beat == 7)) begin errors++; $display("FAIL bp_pop_last: got %0b expected %0b", out_last, (exp_beat == 7)); end
                exp_next = exp_next + 64'd1;
                exp_beat = (exp_beat + 1) % 8;
            end
            tick;
        end
        checks++; if (exp_next !== 64'd104) begin errors++; $display("FAIL bp_count: got %0h expected %0h", exp_next, 64'd104); end
`ifdef FIFO_RD_STATS_EN
        checks++; if (stat_stall_cnt !== 32'd5) begin errors++; $display("FAIL bp_stall_after: got %0d expected 5", stat_stall_cnt); end
`endif
    endtask

    task automatic test_stale_dout;
        stale_val = 64'hDEAD;
        load_stale = 1'b1;
        out_ready = 1'b1;
        tick;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL stale_rd_en c=%0d: got %0b expected 0", c, fifo_rd_en); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stale_valid c=%0d: got %0b expected 0", c, out_valid); end
            tick;
        end
        load_stale = 1'b0;
    endtask

    task automatic test_alternating;
        int issued;
        int popped;
        issued = 0;
        popped = 0;
        exp_next = 64'd300;
        for (int i = 0; i < 12; i++) push(64'd300 + 64'(i));
        for (int c = 0; c < 40; c++) begin
            out_ready = ((c % 2) == 0);
            #1;
            checks++; if ((issued - popped) > 2) begin errors++; $display("FAIL alt_occ c=%0d: got %0d expected <=2", c, issued - popped); end
            if (out_valid && out_ready) begin
                checks++; if (out_data !== exp_next) begin errors++; $display("FAIL alt_data: got %0h expected %0h", out_data, exp_next); end
                checks++; if (out_last !== (exp_beat == 7)) begin errors++; $display("FAIL alt_last: got %0b expected %0b", out_last, (exp_beat == 7)); end
                exp_next = exp_next + 64'd1;
                exp_beat = (exp_beat + 1) % 8;
                popped++;
            end
            if (fifo_rd_en) issued++;
            tick;
        end
        checks++; if (exp_next !== 64'd312) begin errors++; $display("FAIL alt_count: got %0h expected %0h", exp_next, 64'd312); end
        checks++; if (issued !== 12) begin errors++; $display("FAIL alt_issued: got %0d expected 12", issued); end
    endtask

    task automatic test_reset_mid_packet;
        int popped;
        popped = 0;
        exp_next = 64'd400;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) push(64'd400 + 64'(i));
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid && out_ready) begin
                checks++; if (out_data !== exp_next) begin errors++; $display("FAIL rmp_pre_data: got %0h expected %0h", out_data, exp_next); end
                exp_next = exp_next + 64'd1;
                exp_beat = (exp_beat + 1) % 8;
                popped++;
            end
            tick;
            if (popped == 3) break;
        end
        checks++; if (popped !== 3) begin errors++; $display("FAIL rmp_timeout: got %0d pops expected 3", popped); end
        #1;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmp_valid: got %0b expected 0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rmp_last: got %0b expected 0", out_last); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL rmp_data: got %0h expected 0", out_data); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rmp_rd_en: got %0b expected 0", fifo_rd_en); end
        wr_ptr = rd_ptr;
        tick;
        tick;
        rst = 1'b1;
        exp_beat = 0;
        exp_next = 64'd500;
        for (int i = 0; i < 8; i++) push(64'd500 + 64'(i));
        for (int c = 0; c < 14; c++) begin
            #1;
            if (out_valid && out_ready) begin
                checks++; if (out_data !== exp_next) begin errors++; $display("FAIL rmp_post_data: got %0h expected %0h", out_data, exp_next); end
                checks++; if (out_last !== (exp_beat == 7)) begin errors++; $display("FAIL rmp_post_last: got %0b expected %0b", out_last, (exp_beat == 7)); end
                exp_next = exp_next + 64'd1;
                exp_beat = (exp_beat + 1) % 8;
            end
            tick;
        end
        checks++; if (exp_next !== 64'd508) begin errors++; $display("FAIL rmp_post_count: got %0h expected %0h", exp_next, 64'd508); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_empty_gap();
        test_backpressure();
        test_stale_dout();
        test_alternating();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
